avalon_pio_od: RTL and testbench
================================

Name: avalon_pio_od

Overview:
- Parametrised Avalon-MM slave PIO; next generation of the team's single-bit SCL/SDA output ports.
- Provides WIDTH independent pins, each selectable as push-pull or open-drain.
- Adds a direction register, synchronised input sampling, per-bit edge capture and a maskable interrupt.
- Sits between the Nios/Avalon fabric and top-level tristate buffers. Intended for I2C lines (SCL/SDA), codec control and general board GPIO.

Parameters:
- WIDTH, 4, number of pins (1..32).
- RESET_VALUE, 0, reset value of the data_out register (WIDTH bits).
- OPEN_DRAIN, 0, 1 = all pins open-drain (drive low only), 0 = push-pull under the direction register.
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 1, edge capture mode: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register select.
- chipselect  in  1  Avalon chipselect.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  read data, combinational from address.
- pin_in  in  WIDTH  pad input, asynchronous to clk.
- pin_out  out  WIDTH  pad output value.
- pin_oe  out  WIDTH  pad output enable, 1 = drive.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low. All registers clear on reset_n low regardless of clk.
- Reset values: data_out = RESET_VALUE; dir = 0; irq_mask = 0; edge_cap = 0; sync chain and prev = 0; arm counter = 0. Resulting outputs: irq = 0, pin_oe = 0 in push-pull mode, pin_oe = ~RESET_VALUE in open-drain mode.
- Write: occurs when chipselect && !write_n, and takes effect on the next clk edge. Read has zero wait states and no side effects.
- Address map:
  - 0: write sets data_out. Read returns the synchronised pin value (sync_q), not data_out.
  - 1: dir, read/write. In push-pull mode 1 = output. In open-drain mode dir has no effect on pins but remains readable and writable.
  - 2: irq_mask, read/write.
  - 3: edge_cap. Read returns captured edges; writing 1 to a bit clears it; writing 0 has no effect.
  - 4, 5: see Optional Feature.
  - 6, 7: read 0, writes ignored.
- Pin drive:
  - Push-pull: pin_out = data_out, pin_oe = dir.
  - Open-drain: pin_out = 0, pin_oe = ~data_out. Writing 0 pulls the pin low; writing 1 releases it.
- Input path: pin_in passes through a SYNC_STAGES flop chain to give sync_q. prev holds sync_q delayed by one cycle.
- Edge detect: rise = sync_q & ~prev; fall = ~sync_q & prev; EDGE_TYPE selects which is used. Pin-to-capture latency is SYNC_STAGES + 1 cycles.
- Arm counter:
  - After reset, edge detection is suppressed until the counter reaches SYNC_STAGES + 1. The counter then saturates.
  - Purpose: a pin held high through reset must not record a false rising edge.
- Simultaneous events: if a clearing write to edge_cap and a new edge on the same bit land on the same cycle, the edge wins and the bit stays 1.
- irq = |(edge_cap & irq_mask), registered, so it asserts one cycle after edge_cap sets. It deasserts one cycle after the clearing write or the mask write.
- Reset mid-operation: pins return to their reset drive immediately, asynchronously. Pending edges are lost.
- Writes wider than WIDTH are truncated. Unused readdata bits do not exist, because readdata is exactly WIDTH bits.

Optional Feature:
- Macro: AVALON_PIO_OD_BITSET_EN.
- Defined:
  - Address 4 is a set register: data_out |= writedata.
  - Address 5 is a clear register: data_out &= ~writedata.
  - Both are write-only; reads return 0.
  - This gives atomic single-bit manipulation of SCL/SDA without read-modify-write.
- Undefined: addresses 4 and 5 behave like 6 and 7 (read 0, writes ignored). No extra logic is generated.

Test Plan:
- Reset with RESET_VALUE=4'b1010 and OPEN_DRAIN=0 -> readback of addr 1 = 0, pin_oe = 0, pin_out = 1010, irq = 0.
- Push-pull: write dir = 4'b0011, data = 4'b0101 -> pin_oe = 0011 and pin_out = 0101 one cycle after the write. Loop pin_in = pin_out; addr 0 read = 0101 after 2 cycles.
- EDGE_TYPE=1, mask = 4'b0100, pin_in[2] goes 1->0 -> edge_cap = 0100 after 3 cycles and irq = 1 one cycle later. Write 4'b0100 to addr 3 -> irq = 0 next cycle.
- Hold pin_in = 4'b1111 through reset with EDGE_TYPE=0 -> edge_cap stays 0 for 20 cycles after release.
- Clear-vs-edge: write 1 to addr 3 bit 0 on the same cycle bit 0 detects a new edge -> edge_cap[0] = 1 afterwards.
- OPEN_DRAIN=1 with AVALON_PIO_OD_BITSET_EN defined: data = 1111, write addr 5 = 0010 -> pin_oe = 0010, data_out = 1101. Then write addr 4 = 0010 -> pin_oe = 0000.

Source files
------------

// File: rtl/avalon_pio_od.sv
// rtl/avalon_pio_od.sv - Avalon-MM PIO with push-pull/open-drain pins, edge capture and IRQ (optional set/clear registers: AVALON_PIO_OD_BITSET_EN)
module avalon_pio_od #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               OPEN_DRAIN  = 1'b0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    // Edge detection is enabled only once the synchroniser and prev have
    // been refilled from the live pad value after reset.
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [2:0]       r_arm;
    logic             r_irq;

    logic             w_wr;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edges;
    logic             w_armed;
    logic [WIDTH-1:0] w_cap_clr;

    assign w_wr     = chipselect & ~write_n;
    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync_q & ~r_prev;
    assign w_fall   = ~w_sync_q & r_prev;
    assign w_armed  = (r_arm == ARM_MAX);

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge_raw = w_rise;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_raw = w_fall;
        end else begin : g_edge_any
            assign w_edge_raw = w_rise | w_fall;
        end
    endgenerate

    assign w_edges   = w_armed ? w_edge_raw : '0;
    assign w_cap_clr = (w_wr && address == 3'd3) ? writedata : '0;

    // Output data register, with optional atomic set/clear aliases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
        end else if (w_wr && address == 3'd0) begin
            r_data_out <= writedata;
`ifdef AVALON_PIO_OD_BITSET_EN
        end else if (w_wr && address == 3'd4) begin
            r_data_out <= r_data_out | writedata;
        end else if (w_wr && address == 3'd5) begin
            r_data_out <= r_data_out & ~writedata;
`endif
        end
    end

    // Direction and interrupt mask registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir      <= '0;
            r_irq_mask <= '0;
        end else begin
            if (w_wr && address == 3'd1) r_dir      <= writedata;
            if (w_wr && address == 3'd2) r_irq_mask <= writedata;
        end
    end

    // Pad input synchroniser chain and one-cycle delayed copy for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_sync_q;
        end
    end

    // Saturating arm counter that masks false edges right after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 3'd1;
        end
    end

    // Edge capture: write-1-to-clear, a new edge in the same cycle wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edges;
        end
    end

    // Registered level interrupt from masked captured edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

    // Zero-wait-state read mux; address 0 returns the synchronised pads
    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = w_sync_q;
            3'd1:    readdata = r_dir;
            3'd2:    readdata = r_irq_mask;
            3'd3:    readdata = r_edge_cap;
            default: readdata = '0;
        endcase
    end

    generate
        if (OPEN_DRAIN) begin : g_od
            // Only ever drive low; a 1 in data_out releases the line
            assign pin_out = '0;
            assign pin_oe  = ~r_data_out;
        end else begin : g_pp
            assign pin_out = r_data_out;
            assign pin_oe  = r_dir;
        end
    endgenerate

    assign irq = r_irq;

endmodule

// File: tb/tb_avalon_pio_od.sv
// tb/tb_avalon_pio_od.sv - scoreboard bench for avalon_pio_od
module tb_avalon_pio_od;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] address;
    logic       write_n;
    logic [3:0] writedata;
    logic       cs0, cs1, cs2;
    logic [3:0] pin_in0, pin_in1, pin_in2;
    logic [3:0] rd0, rd1, rd2;
    logic [3:0] po0, po1, po2;
    logic [3:0] oe0, oe1, oe2;
    logic       irq0, irq1, irq2;

    int n_checks = 0;
    int n_fail   = 0;

    int         q_sel [$];
    logic [3:0] q_exp [$];
    string      q_nm  [$];

    always #5 clk = ~clk;

    avalon_pio_od #(.WIDTH(4), .RESET_VALUE(4'b1010), .OPEN_DRAIN(1'b0), .SYNC_STAGES(2), .EDGE_TYPE(1)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0), .write_n(write_n),
        .writedata(writedata), .readdata(rd0), .pin_in(pin_in0), .pin_out(po0), .pin_oe(oe0), .irq(irq0));

    avalon_pio_od #(.WIDTH(4), .RESET_VALUE(4'b0000), .OPEN_DRAIN(1'b0), .SYNC_STAGES(2), .EDGE_TYPE(0)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .pin_in(pin_in1), .pin_out(po1), .pin_oe(oe1), .irq(irq1));

    avalon_pio_od #(.WIDTH(4), .RESET_VALUE(4'b0000), .OPEN_DRAIN(1'b1), .SYNC_STAGES(2), .EDGE_TYPE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2), .write_n(write_n),
        .writedata(writedata), .readdata(rd2), .pin_in(pin_in2), .pin_out(po2), .pin_oe(oe2), .irq(irq2));

    function automatic logic [3:0] obs(input int sel);
        case (sel)
            0:  return rd0;
            1:  return po0;
            2:  return oe0;
            3:  return {3'b000, irq0};
            4:  return rd1;
            5:  return po1;
            6:  return oe1;
            7:  return {3'b000, irq1};
            8:  return rd2;
            9:  return po2;
            10: return oe2;
            11: return {3'b000, irq2};
            default: return 4'b0000;
        endcase
    endfunction

    // Monitor: pops every pending expectation and compares on the falling edge
    always @(negedge clk) begin
        int         s;
        logic [3:0] e;
        string      nm;
        logic [3:0] a;
        while (q_sel.size() > 0) begin
            s  = q_sel.pop_front();
            e  = q_exp.pop_front();
            nm = q_nm.pop_front();
            a  = obs(s);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [3:0] e, input string nm);
        q_sel.push_back(sel);
        q_exp.push_back(e);
        q_nm.push_back(nm);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int which, input logic [2:0] a, input logic [3:0] d);
        cs0 = (which == 0);
        cs1 = (which == 1);
        cs2 = (which == 2);
        write_n   = 1'b0;
        address   = a;
        writedata = d;
        tick(1);
        cs0 = 1'b0;
        cs1 = 1'b0;
        cs2 = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        address = 3'd1;
        write_n = 1'b1;
        writedata = 4'b0000;
        cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
        pin_in0 = 4'b0000;
        pin_in1 = 4'b1111;
        pin_in2 = 4'b0000;
        tick(3);

        // Reset state
        expect_v(0,  4'b0000, "rst_dir_rd0");
        expect_v(2,  4'b0000, "rst_oe0");
        expect_v(1,  4'b1010, "rst_pout0");
        expect_v(3,  4'b0000, "rst_irq0");
        expect_v(10, 4'b1111, "rst_oe2_od");
        expect_v(9,  4'b0000, "rst_pout2_od");
        settle();

        // Pad held high through reset on the rising-edge instance
        address = 3'd3;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            expect_v(4, 4'b0000, "arm_no_false_rise");
            settle();
        end

        // Push-pull drive and input loopback
        wr(0, 3'd1, 4'b0011);
        wr(0, 3'd0, 4'b0101);
        expect_v(2, 4'b0011, "pp_oe0");
        expect_v(1, 4'b0101, "pp_pout0");
        settle();
        tick(1);
        address = 3'd0;
        pin_in0 = 4'b0101;
        tick(1);
        expect_v(0, 4'b0000, "sync_lat1");
        settle();
        tick(1);
        expect_v(0, 4'b0101, "sync_lat2");
        settle();

        // Falling edge capture and interrupt
        tick(1);
        wr(0, 3'd2, 4'b0100);
        address = 3'd3;
        pin_in0 = 4'b0001;
        tick(2);
        expect_v(0, 4'b0000, "fall_cap_early");
        settle();
        tick(1);
        expect_v(0, 4'b0100, "fall_cap");
        expect_v(3, 4'b0000, "irq_not_yet");
        settle();
        tick(1);
        expect_v(3, 4'b0001, "irq_set");
        settle();
        tick(1);
        wr(0, 3'd3, 4'b0100);
        expect_v(0, 4'b0000, "cap_cleared");
        settle();
        tick(1);
        expect_v(3, 4'b0000, "irq_cleared");
        settle();
        tick(1);
        pin_in0 = 4'b0101;
        tick(5);
        expect_v(0, 4'b0000, "rise_ignored_fall_mode");
        settle();

        // Unused addresses read 0 and ignore writes
        tick(1);
        wr(0, 3'd6, 4'b1111);
        wr(0, 3'd7, 4'b1111);
        address = 3'd6;
        expect_v(0, 4'b0000, "addr6_rd0");
        settle();
        tick(1);
        address = 3'd1;
        expect_v(0, 4'b0011, "dir_untouched");
        expect_v(1, 4'b0101, "dout_untouched");
        settle();

        // Clear write and new rising edge on the same cycle
        tick(1);
        pin_in1 = 4'b1110;
        tick(5);
        pin_in1 = 4'b1111;
        tick(2);
        wr(1, 3'd3, 4'b0001);
        address = 3'd3;
        expect_v(4, 4'b0001, "edge_beats_clear");
        expect_v(7, 4'b0000, "irq1_masked");
        settle();
        tick(1);
        wr(1, 3'd3, 4'b0001);
        expect_v(4, 4'b0000, "plain_clear");
        settle();

        // Open-drain drive, dir ignored for pins
        tick(1);
        wr(2, 3'd0, 4'b1111);
        expect_v(10, 4'b0000, "od_release");
        expect_v(9,  4'b0000, "od_pout");
        settle();
        tick(1);
        wr(2, 3'd1, 4'b1111);
        address = 3'd1;
        expect_v(10, 4'b0000, "od_dir_no_effect");
        expect_v(8,  4'b1111, "od_dir_rd");
        settle();
        tick(1);
`ifdef AVALON_PIO_OD_BITSET_EN
        wr(2, 3'd5, 4'b0010);
        expect_v(10, 4'b0010, "bitclr_oe");
        settle();
        tick(1);
        wr(2, 3'd4, 4'b0010);
        expect_v(10, 4'b0000, "bitset_oe");
        settle();
`else
        wr(2, 3'd5, 4'b0010);
        expect_v(10, 4'b0000, "addr5_ignored");
        settle();
        tick(1);
        wr(2, 3'd4, 4'b0000);
        expect_v(10, 4'b0000, "addr4_ignored");
        settle();
`endif
        tick(1);
        address = 3'd4;
        expect_v(8, 4'b0000, "addr4_rd0");
        settle();
        tick(1);
        address = 3'd5;
        expect_v(8, 4'b0000, "addr5_rd0");
        settle();
        tick(1);
        wr(2, 3'd0, 4'b0110);
        expect_v(10, 4'b1001, "od_partial");
        settle();

        // Any-edge capture: rise then fall
        tick(1);
        address = 3'd3;
        pin_in2 = 4'b0001;
        tick(3);
        expect_v(8, 4'b0001, "any_rise");
        settle();
        tick(1);
        wr(2, 3'd3, 4'b0001);
        pin_in2 = 4'b0000;
        tick(3);
        expect_v(8, 4'b0001, "any_fall");
        settle();

        // Asynchronous reset mid-operation
        tick(1);
        address = 3'd1;
        reset_n = 1'b0;
        #1;
        expect_v(1,  4'b1010, "async_rst_pout0");
        expect_v(2,  4'b0000, "async_rst_oe0");
        expect_v(0,  4'b0000, "async_rst_dir0");
        expect_v(10, 4'b1111, "async_rst_oe2");
        settle();
        tick(2);
        address = 3'd3;
        expect_v(8, 4'b0000, "async_rst_cap2");
        settle();

        for (int i = 0; i < 10 && q_sel.size() > 0; i++) settle();
        if (q_sel.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_sel.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
